register_file: RTL and testbench

- Parametrised multi-register storage block for the single-cycle datapath: NREG registers of W bits each.
- One synchronous write port and two asynchronous read ports, which feed the ALU operand A and B selects.
- A sequential bulk-clear engine zeroes the file one register per cycle without asserting global reset.
- Status outputs report clear progress and dropped writes to the control unit.

---
 rtl/regfile_pkg.sv | 15 +
 rtl/regfile_cell.sv | 28 ++
 rtl/register_file.sv | 122 ++++++++++++
 tb/tb_register_file.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the register file slice.
// No logic; compile before any file that imports it.
// No flow control here.
package regfile_pkg;

    localparam int REGFILE_W    = 4;
    localparam int REGFILE_NREG = 8;

    // Clear-engine state: IDLE accepts writes, CLEAR zeroes one register per cycle
    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/regfile_cell.sv
// One W-bit storage register with a synchronous active-low reset, clear strobe and write enable.
// Latency: 1 cycle from wen/clr to q.
// No backpressure; priority is reset, then clear, then write, otherwise hold.
import regfile_pkg::*;

module regfile_cell #(
    parameter int W = REGFILE_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wen,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Storage: clear strobe beats a write so the clear engine always wins
    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (wen) begin
            q <= d;
        end
    end

endmodule

// File: rtl/register_file.sv
// NREG x W register file: one sync write port, two async read ports, sequential bulk-clear engine.
// Latency: writes visible next cycle (same cycle on reads when REGFILE_BYPASS_EN is defined); clear takes NREG cycles.
// No stall: writes arriving with clr or during a clear are refused and flagged by a registered wr_drop pulse.
import regfile_pkg::*;

module register_file #(
    parameter  int W    = REGFILE_W,
    parameter  int NREG = REGFILE_NREG,
    localparam int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wen,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr_a,
    output logic [W-1:0]  rdata_a,
    input  logic [AW-1:0] raddr_b,
    output logic [W-1:0]  rdata_b,
    input  logic          clr,
    output logic          busy,
    output logic          clr_done,
    output logic          wr_drop
);

    localparam logic [AW-1:0] LAST = AW'(NREG - 1);

    state_t        state, state_nxt;
    logic [AW-1:0] cnt;
    logic          in_clear;
    logic          cnt_last;
    logic          waddr_ok;
    logic          wr_acc;
    logic          wr_refused;
    logic [NREG-1:0] cell_wen;
    logic [NREG-1:0] cell_clr;
    logic [W-1:0]    cell_q [NREG];

    assign in_clear   = (state == CLEAR);
    assign cnt_last   = (cnt == LAST);
    assign waddr_ok   = (32'(waddr) < NREG);
    assign wr_acc     = (state == IDLE) && wen && !clr && waddr_ok;
    // A clr request in IDLE takes priority over a simultaneous write
    assign wr_refused = wen && (in_clear || clr);

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: clr while clearing is ignored, exit after the last register
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (clr) state_nxt = CLEAR;
            CLEAR:   if (cnt_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: busy for the whole clear, done pulse in its final cycle
    always_comb begin
        busy     = in_clear;
        clr_done = in_clear && cnt_last;
    end

    // Clear counter: parked at 0 in IDLE, steps once per clear cycle, never passes NREG-1
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (!in_clear || cnt_last) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Registered refusal flag, one cycle after the refused write
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_drop <= 1'b0;
        end else begin
            wr_drop <= wr_refused;
        end
    end

    // One cell per register; decode write enable and clear strobe per index
    for (genvar i = 0; i < NREG; i++) begin : g_cell
        assign cell_wen[i] = wr_acc && (waddr == AW'(i));
        assign cell_clr[i] = in_clear && (cnt == AW'(i));

        regfile_cell #(.W(W)) u_cell (
            .clk (clk),
            .rst (rst),
            .wen (cell_wen[i]),
            .clr (cell_clr[i]),
            .d   (wdata),
            .q   (cell_q[i])
        );
    end

    // Read muxes: unmatched (out-of-range) addresses return 0; optional write-through forwarding
    always_comb begin
        rdata_a = '0;
        rdata_b = '0;
        for (int i = 0; i < NREG; i++) begin
            if (raddr_a == AW'(i)) rdata_a = cell_q[i];
            if (raddr_b == AW'(i)) rdata_b = cell_q[i];
        end
`ifdef REGFILE_BYPASS_EN
        if (wr_acc && (raddr_a == waddr)) rdata_a = wdata;
        if (wr_acc && (raddr_b == waddr)) rdata_b = wdata;
`else
        // Without forwarding a same-cycle read sees the stored value
`endif
    end

endmodule

// File: tb/tb_register_file.sv
`timescale 1ns/100ps

module tb_register_file;

    localparam int N = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wen = 1'b0;
    logic [2:0] waddr = '0;
    logic [3:0] wdata = '0;
    logic [2:0] raddr_a = '0;
    logic [2:0] raddr_b = '0;
    logic [3:0] rdata_a, rdata_b;
    logic       clr = 1'b0;
    logic       busy, clr_done, wr_drop;

    logic       w6_en = 1'b0;
    logic [2:0] w6_addr = '0;
    logic [3:0] w6_data = '0;
    logic [2:0] ra6 = '0;
    logic [2:0] rb6 = '0;
    logic [3:0] rd6_a, rd6_b;
    logic       clr6 = 1'b0;
    logic       busy6, done6, drop6;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: register contents plus clear progress as a count of cleared registers
    int m_reg [N];
    bit m_busy  = 1'b0;
    int m_done_cnt = 0;
    bit m_drop  = 1'b0;

    register_file dut (
        .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .rdata_a(rdata_a), .raddr_b(raddr_b), .rdata_b(rdata_b),
        .clr(clr), .busy(busy), .clr_done(clr_done), .wr_drop(wr_drop)
    );

    register_file #(.W(4), .NREG(6)) dut6 (
        .clk(clk), .rst(rst), .wen(w6_en), .waddr(w6_addr), .wdata(w6_data),
        .raddr_a(ra6), .rdata_a(rd6_a), .raddr_b(rb6), .rdata_b(rd6_b),
        .clr(clr6), .busy(busy6), .clr_done(done6), .wr_drop(drop6)
    );

    always #5 clk = ~clk;

    // Advance one clock; the model applies the rules to the inputs present at the edge
    task automatic tick();
        int nr [N];
        bit nb;
        int nc;
        bit nd;
        nr = m_reg;
        nb = m_busy;
        nc = m_done_cnt;
        nd = 1'b0;
        if (!rst) begin
            foreach (nr[i]) nr[i] = 0;
            nb = 1'b0;
            nc = 0;
        end else begin
            nd = wen && (m_busy || clr);
            if (m_busy) begin
                nr[m_done_cnt] = 0;
                nc = m_done_cnt + 1;
                if (nc == N) begin
                    nb = 1'b0;
                    nc = 0;
                end
            end else if (clr) begin
                nb = 1'b1;
                nc = 0;
            end else if (wen && int'(waddr) < N) begin
                nr[waddr] = int'(wdata);
            end
        end
        @(posedge clk);
        m_reg = nr;
        m_busy = nb;
        m_done_cnt = nc;
        m_drop = nd;
        #1;
    endtask

    function automatic int exp_rd(input int a);
`ifdef REGFILE_BYPASS_EN
        if (rst && !m_busy && wen && !clr && int'(waddr) == a) return int'(wdata);
`endif
        return m_reg[a];
    endfunction

    function automatic bit exp_done();
        return m_busy && (m_done_cnt == N - 1);
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        tick(); tick();
        rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            wen = 1'b1; waddr = 3'($urandom_range(0, 7)); wdata = 4'($urandom_range(1, 15));
            tick();
        end
        wen = 1'b0;
        rst = 1'b0;
        wen = 1'b1; clr = 1'b1;
        tick(); tick();
        wen = 1'b0; clr = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_checks++; if (clr_done !== 1'b0) begin n_fail++; $display("FAIL reset_clr_done got=%b exp=0", clr_done); end
        n_checks++; if (wr_drop !== 1'b0) begin n_fail++; $display("FAIL reset_wr_drop got=%b exp=0", wr_drop); end
        for (int i = 0; i < N; i++) begin
            raddr_a = 3'(i); raddr_b = 3'(N - 1 - i); #1;
            n_checks++; if (rdata_a !== 4'h0) begin n_fail++; $display("FAIL reset_rd_a[%0d] got=%h exp=0", i, rdata_a); end
            n_checks++; if (rdata_b !== 4'h0) begin n_fail++; $display("FAIL reset_rd_b[%0d] got=%h exp=0", N - 1 - i, rdata_b); end
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_write_read();
        wen = 1'b1; waddr = 3'd3; wdata = 4'hA; tick();
        waddr = 3'd7; wdata = 4'h5; tick();
        wen = 1'b0;
        raddr_a = 3'd3; raddr_b = 3'd7; #1;
        n_checks++; if (rdata_a !== 4'hA) begin n_fail++; $display("FAIL wr_rd_r3 got=%h exp=a", rdata_a); end
        n_checks++; if (rdata_b !== 4'h5) begin n_fail++; $display("FAIL wr_rd_r7 got=%h exp=5", rdata_b); end
        for (int k = 0; k < 5; k++) tick();
        n_checks++; if (rdata_a !== 4'hA) begin n_fail++; $display("FAIL hold_r3 got=%h exp=a", rdata_a); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 60; k++) begin
            wen = 1'($urandom_range(0, 1));
            clr = ($urandom_range(0, 11) == 0);
            waddr = 3'($urandom); wdata = 4'($urandom);
            raddr_a = 3'($urandom); raddr_b = 3'($urandom);
            #1;
            n_checks++; if (int'(rdata_a) !== exp_rd(int'(raddr_a))) begin n_fail++; $display("FAIL rand_rd_a cyc=%0d addr=%0d got=%h exp=%h", k, raddr_a, rdata_a, exp_rd(int'(raddr_a))); end
            n_checks++; if (int'(rdata_b) !== exp_rd(int'(raddr_b))) begin n_fail++; $display("FAIL rand_rd_b cyc=%0d addr=%0d got=%h exp=%h", k, raddr_b, rdata_b, exp_rd(int'(raddr_b))); end
            n_checks++; if (busy !== m_busy) begin n_fail++; $display("FAIL rand_busy cyc=%0d got=%b exp=%b", k, busy, m_busy); end
            n_checks++; if (clr_done !== exp_done()) begin n_fail++; $display("FAIL rand_clr_done cyc=%0d got=%b exp=%b", k, clr_done, exp_done()); end
            n_checks++; if (wr_drop !== m_drop) begin n_fail++; $display("FAIL rand_wr_drop cyc=%0d got=%b exp=%b", k, wr_drop, m_drop); end
            tick();
        end
        wen = 1'b0; clr = 1'b0;
        for (int k = 0; k < 10 && m_busy; k++) tick();
    endtask

    task automatic test_bulk_clear();
        for (int i = 0; i < N; i++) begin
            wen = 1'b1; waddr = 3'(i); wdata = 4'hF; tick();
        end
        wen = 1'b0;
        clr = 1'b1; tick(); clr = 1'b0;
        for (int c = 1; c <= N; c++) begin
            n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL clr_busy cyc=%0d got=%b exp=1", c, busy); end
            n_checks++; if (clr_done !== (c == N)) begin n_fail++; $display("FAIL clr_done cyc=%0d got=%b exp=%b", c, clr_done, (c == N)); end
            if (c == 4) begin
                for (int i = 0; i < N; i++) begin
                    raddr_a = 3'(i); #1;
                    n_checks++; if (rdata_a !== ((i < 3) ? 4'h0 : 4'hF)) begin n_fail++; $display("FAIL mid_clr_r%0d got=%h exp=%h", i, rdata_a, (i < 3) ? 4'h0 : 4'hF); end
                end
            end
            if (c == 5) clr = 1'b1;
            tick();
            clr = 1'b0;
        end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clr_end_busy got=%b exp=0", busy); end
        n_checks++; if (clr_done !== 1'b0) begin n_fail++; $display("FAIL clr_end_done got=%b exp=0", clr_done); end
        for (int i = 0; i < N; i++) begin
            raddr_b = 3'(i); #1;
            n_checks++; if (rdata_b !== 4'h0) begin n_fail++; $display("FAIL clr_end_r%0d got=%h exp=0", i, rdata_b); end
        end
    endtask

    task automatic test_conflicts();
        wen = 1'b1; waddr = 3'd1; wdata = 4'h7; tick();
        wdata = 4'h2; clr = 1'b1; raddr_a = 3'd1; #1;
        n_checks++; if (rdata_a !== 4'h7) begin n_fail++; $display("FAIL clr_wen_no_bypass got=%h exp=7", rdata_a); end
        tick();
        wen = 1'b0; clr = 1'b0;
        n_checks++; if (wr_drop !== 1'b1) begin n_fail++; $display("FAIL clr_wen_drop got=%b exp=1", wr_drop); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL clr_wen_busy got=%b exp=1", busy); end
        tick();
        n_checks++; if (wr_drop !== 1'b0) begin n_fail++; $display("FAIL clr_wen_drop_pulse got=%b exp=0", wr_drop); end
        for (int k = 0; k < 10 && m_busy; k++) tick();

        wen = 1'b1; waddr = 3'd5; wdata = 4'hB; tick();
        wen = 1'b0; clr = 1'b1; tick(); clr = 1'b0;
        tick();
        wen = 1'b1; waddr = 3'd5; wdata = 4'h6; tick();
        wen = 1'b0;
        raddr_a = 3'd5; #1;
        n_checks++; if (wr_drop !== 1'b1) begin n_fail++; $display("FAIL busy_wen_drop got=%b exp=1", wr_drop); end
        n_checks++; if (rdata_a !== 4'hB) begin n_fail++; $display("FAIL busy_wen_r5_kept got=%h exp=b", rdata_a); end
        for (int k = 0; k < 10 && m_busy; k++) tick();
        n_checks++; if (rdata_a !== 4'h0) begin n_fail++; $display("FAIL busy_wen_r5_end got=%h exp=0", rdata_a); end
        n_checks++; if (wr_drop !== 1'b0) begin n_fail++; $display("FAIL busy_wen_drop_end got=%b exp=0", wr_drop); end
    endtask

    task automatic test_reset_mid_clear();
        for (int i = 0; i < N; i++) begin
            wen = 1'b1; waddr = 3'(i); wdata = 4'($urandom_range(1, 15)); tick();
        end
        wen = 1'b0;
        clr = 1'b1; tick(); clr = 1'b0;
        tick(); tick(); tick();
        rst = 1'b0; tick(); rst = 1'b1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
        n_checks++; if (clr_done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_done got=%b exp=0", clr_done); end
        for (int i = 0; i < N; i++) begin
            raddr_a = 3'(i); #1;
            n_checks++; if (rdata_a !== 4'h0) begin n_fail++; $display("FAIL rst_mid_r%0d got=%h exp=0", i, rdata_a); end
        end
        for (int k = 0; k < 10; k++) begin
            tick();
            n_checks++; if (clr_done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_idle cyc=%0d done=%b busy=%b exp=0", k, clr_done, busy); end
        end
    endtask

    task automatic test_bypass();
        logic [3:0] exp_same;
`ifdef REGFILE_BYPASS_EN
        exp_same = 4'h9;
`else
        exp_same = 4'h3;
`endif
        wen = 1'b1; waddr = 3'd2; wdata = 4'h3; tick();
        wdata = 4'h9; raddr_a = 3'd2; raddr_b = 3'd2; #1;
        n_checks++; if (rdata_a !== exp_same) begin n_fail++; $display("FAIL same_cyc_rd_a got=%h exp=%h", rdata_a, exp_same); end
        n_checks++; if (rdata_b !== exp_same) begin n_fail++; $display("FAIL same_cyc_rd_b got=%h exp=%h", rdata_b, exp_same); end
        tick();
        wen = 1'b0; #1;
        n_checks++; if (rdata_a !== 4'h9) begin n_fail++; $display("FAIL next_cyc_rd_a got=%h exp=9", rdata_a); end
    endtask

    task automatic test_nreg6();
        w6_en = 1'b1; w6_addr = 3'd5; w6_data = 4'hC; tick();
        w6_addr = 3'd7; w6_data = 4'h3; ra6 = 3'd7; #1;
        n_checks++; if (rd6_a !== 4'h0) begin n_fail++; $display("FAIL n6_oor_no_bypass got=%h exp=0", rd6_a); end
        tick();
        w6_addr = 3'd6; w6_data = 4'h5; tick();
        w6_en = 1'b0;
        n_checks++; if (drop6 !== 1'b0) begin n_fail++; $display("FAIL n6_oor_drop got=%b exp=0", drop6); end
        ra6 = 3'd5; rb6 = 3'd6; #1;
        n_checks++; if (rd6_a !== 4'hC) begin n_fail++; $display("FAIL n6_r5 got=%h exp=c", rd6_a); end
        n_checks++; if (rd6_b !== 4'h0) begin n_fail++; $display("FAIL n6_raddr6 got=%h exp=0", rd6_b); end
        ra6 = 3'd7; rb6 = 3'd0; #1;
        n_checks++; if (rd6_a !== 4'h0) begin n_fail++; $display("FAIL n6_raddr7 got=%h exp=0", rd6_a); end
        n_checks++; if (rd6_b !== 4'h0) begin n_fail++; $display("FAIL n6_r0 got=%h exp=0", rd6_b); end
    endtask

    initial begin
        foreach (m_reg[i]) m_reg[i] = 0;
        test_reset();
        test_write_read();
        test_bulk_clear();
        test_conflicts();
        test_reset_mid_clear();
        test_bypass();
        test_random();
        test_nreg6();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
